// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, datapath width and multiply sequencer states.
package alu_pkg;

    localparam int WIDTH  = 16;
    localparam int ITER_W = 4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_BNE = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/alu_16_bit.sv
// Shared 16-bit combinational ALU; shifts move operand b by one bit.
module alu_16_bit
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SUB: result = a - b;
            ALU_SLL: result = b << 1;
            ALU_SRL: result = b >> 1;
            ALU_BNE: result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add 16x16 multiplier (low half) driving the shared ALU.
// Define MULT_EARLY_EXIT_EN to stop once the remaining multiplier is zero.
module alu_mult_sequencer
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam logic [ITER_W-1:0] ITER_LAST = '1;

    seq_state_t        state, state_nx;
    logic [WIDTH-1:0]  acc, acc_nx;
    logic [WIDTH-1:0]  mcand, mcand_nx;
    logic [WIDTH-1:0]  mplier, mplier_nx;
    logic [ITER_W-1:0] iter, iter_nx;
    logic              finish;

`ifdef MULT_EARLY_EXIT_EN
    assign finish = alu_zero || (iter == ITER_LAST);
`else
    logic unused_zero;
    assign unused_zero = alu_zero;
    assign finish      = (iter == ITER_LAST);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            iter   <= '0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            iter   <= iter_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        mcand_nx  = mcand;
        mplier_nx = mplier;
        iter_nx   = iter;
        alu_op    = ALU_ADD;
        alu_a     = '0;
        alu_b     = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    acc_nx    = '0;
                    mcand_nx  = mcand_in;
                    mplier_nx = mplier_in;
                    iter_nx   = '0;
                    state_nx  = mplier_in[0] ? S_ADD : S_SHL;
                end
            end
            S_ADD: begin
                alu_a    = acc;
                alu_b    = mcand;
                acc_nx   = alu_result;
                state_nx = S_SHL;
            end
            S_SHL: begin
                alu_op   = ALU_SLL;
                alu_b    = mcand;
                mcand_nx = alu_result;
                state_nx = S_SHR;
            end
            S_SHR: begin
                alu_op    = ALU_SRL;
                alu_b     = mplier;
                mplier_nx = alu_result;
                if (finish) begin
                    state_nx = S_DONE;
                end else begin
                    iter_nx  = iter + 1'b1;
                    state_nx = alu_result[0] ? S_ADD : S_SHL;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy    = (state == S_ADD) || (state == S_SHL) || (state == S_SHR);
    assign done    = (state == S_DONE);
    assign product = acc;

endmodule
